// File: rtl/imm_gen_arbiter.sv
// Two-port round-robin front end for a shared RISC-V immediate generator.
// The winner's decoded immediate, instruction, source and tag go into one registered output slot.
module imm_gen_arbiter #(
   parameter int TAG_W = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   input  logic [31:0]      req0_inst,
   input  logic [TAG_W-1:0] req0_tag,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [31:0]      req1_inst,
   input  logic [TAG_W-1:0] req1_tag,
   output logic             req1_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_imm,
   output logic [31:0]      out_inst,
   output logic             out_src,
   output logic [TAG_W-1:0] out_tag,
   input  logic             cnt_clear,
   output logic [CNT_W-1:0] grant_cnt0,
   output logic [CNT_W-1:0] grant_cnt1
);

   function automatic logic [31:0] imm_decode(input logic [31:0] inst);
      logic [31:0] imm;
      unique case ({inst[6:5], inst[3:2]})
         4'b1101:          imm = {{20{inst[31]}}, inst[31:21], 1'b0};
         4'b0100:          imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         4'b0101, 4'b0001: imm = {inst[31:12], 12'b0};
         4'b1111:          imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         4'b1100:          imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         default:          imm = {{20{inst[31]}}, inst[31:20]};
      endcase
      return imm;
   endfunction

   logic                        out_valid_q, out_valid_d;
   logic [31:0]                 out_imm_q, out_inst_q;
   logic                        out_src_q;
   logic [TAG_W-1:0]            out_tag_q;
   logic                        last_grant_q;
   logic [1:0][CNT_W-1:0]       cnt_q, cnt_d;

   logic              slot_free, gnt0, gnt1, any_gnt;
   logic [31:0]       sel_inst;
   logic [TAG_W-1:0]  sel_tag;

   // last_grant_q==1 means requester 0 has priority on contention.
   assign slot_free = !out_valid_q | out_ready;
   assign gnt0      = slot_free & req0_valid & (!req1_valid |  last_grant_q);
   assign gnt1      = slot_free & req1_valid & (!req0_valid | !last_grant_q);
   assign any_gnt   = gnt0 | gnt1;
   assign sel_inst  = gnt1 ? req1_inst : req0_inst;
   assign sel_tag   = gnt1 ? req1_tag  : req0_tag;

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;

   always_comb begin
      out_valid_d = out_valid_q;
      if (any_gnt)        out_valid_d = 1'b1;
      else if (out_ready) out_valid_d = 1'b0;
   end

   always_comb begin
      cnt_d = cnt_q;
      for (int i = 0; i < 2; i++) begin
         if (cnt_clear)
            cnt_d[i] = '0;
         else if (((i == 0) ? gnt0 : gnt1) && (cnt_q[i] != {CNT_W{1'b1}}))
            cnt_d[i] = cnt_q[i] + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_imm_q    <= '0;
         out_inst_q   <= '0;
         out_src_q    <= 1'b0;
         out_tag_q    <= '0;
         last_grant_q <= 1'b1;
         cnt_q        <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         cnt_q       <= cnt_d;
         if (any_gnt) begin
            out_imm_q    <= imm_decode(sel_inst);
            out_inst_q   <= sel_inst;
            out_src_q    <= gnt1;
            out_tag_q    <= sel_tag;
            last_grant_q <= gnt1;
         end
      end
   end

   assign out_valid  = out_valid_q;
   assign out_imm    = out_imm_q;
   assign out_inst   = out_inst_q;
   assign out_src    = out_src_q;
   assign out_tag    = out_tag_q;
   assign grant_cnt0 = cnt_q[0];
   assign grant_cnt1 = cnt_q[1];

endmodule

// File: tb/tb_imm_gen_arbiter.sv
// Randomized bench for imm_gen_arbiter against a transaction-level reference model.
module tb_imm_gen_arbiter;
   localparam int TAG_W = 4;
   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic             req0_valid, req1_valid, req0_ready, req1_ready;
   logic [31:0]      req0_inst, req1_inst;
   logic [TAG_W-1:0] req0_tag, req1_tag;
   logic             out_valid, out_ready, out_src, cnt_clear;
   logic [31:0]      out_imm, out_inst;
   logic [TAG_W-1:0] out_tag;
   logic [CNT_W-1:0] grant_cnt0, grant_cnt1;

   imm_gen_arbiter #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_inst(req0_inst), .req0_tag(req0_tag), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_inst(req1_inst), .req1_tag(req1_tag), .req1_ready(req1_ready),
      .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_inst(out_inst),
      .out_src(out_src), .out_tag(out_tag), .cnt_clear(cnt_clear),
      .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
   );

   int errs = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference immediate built from field arithmetic on the instruction word.
   function automatic logic [31:0] ref_imm(input logic [31:0] x);
      logic [31:0] a20, a25, a31;
      a20 = $signed(x) >>> 20;
      a25 = $signed(x) >>> 25;
      a31 = $signed(x) >>> 31;
      case ({x[6:5], x[3:2]})
         4'b0100:          return (a25 << 5) | ((x >> 7) & 32'h1F);
         4'b0101, 4'b0001: return x & 32'hFFFFF000;
         4'b1101:          return a20 & ~32'd1;
         4'b1111:          return (a31 << 20) | (x & 32'h000FF000) | (((x >> 20) & 32'h1) << 11)
                                  | (((x >> 21) & 32'h3FF) << 1);
         4'b1100:          return (a31 << 12) | (((x >> 7) & 32'h1) << 11) | (((x >> 25) & 32'h3F) << 5)
                                  | (((x >> 8) & 32'hF) << 1);
         default:          return a20;
      endcase
   endfunction

   // Model state
   bit          m_valid, m_src, m_last;
   logic [31:0] m_imm, m_inst;
   logic [3:0]  m_tag;
   int          m_cnt[2];

   task automatic m_reset();
      m_valid = 0; m_src = 0; m_last = 1; m_imm = 0; m_inst = 0; m_tag = 0;
      m_cnt[0] = 0; m_cnt[1] = 0;
   endtask

   task automatic chk_out();
      chk("out_valid", out_valid, m_valid);
      chk("out_imm",   out_imm,   m_imm);
      chk("out_inst",  out_inst,  m_inst);
      chk("out_src",   out_src,   m_src);
      chk("out_tag",   out_tag,   m_tag);
      chk("grant_cnt0", grant_cnt0, m_cnt[0]);
      chk("grant_cnt1", grant_cnt1, m_cnt[1]);
   endtask

   task automatic cyc(input bit v0, input logic [31:0] i0, input logic [3:0] t0,
                      input bit v1, input logic [31:0] i1, input logic [3:0] t1,
                      input bit ordy, input bit clr);
      bit free, g0, g1;
      int w;
      @(negedge clk);
      chk_out();
      req0_valid = v0; req0_inst = i0; req0_tag = t0;
      req1_valid = v1; req1_inst = i1; req1_tag = t1;
      out_ready = ordy; cnt_clear = clr;
      #1;
      free = !m_valid || ordy;
      g0 = free && v0 && (!v1 || m_last);
      g1 = free && v1 && (!v0 || !m_last);
      chk("req0_ready", req0_ready, g0);
      chk("req1_ready", req1_ready, g1);
      @(posedge clk);
      if (g0 || g1) begin
         w = g1 ? 1 : 0;
         m_valid = 1; m_src = g1; m_last = g1;
         m_inst = g1 ? i1 : i0;
         m_tag  = g1 ? t1 : t0;
         m_imm  = ref_imm(m_inst);
         if (!clr && m_cnt[w] < CMAX) m_cnt[w]++;
      end else if (ordy) begin
         m_valid = 0;
      end
      if (clr) begin m_cnt[0] = 0; m_cnt[1] = 0; end
   endtask

   logic [6:0] ops [8] = '{7'h13, 7'h67, 7'h23, 7'h37, 7'h17, 7'h6F, 7'h63, 7'h0B};

   function automatic logic [31:0] rnd_inst();
      logic [31:0] x;
      x = $urandom;
      x[6:0] = ops[$urandom_range(0, 7)];
      return x;
   endfunction

   initial begin
      rst_n = 0;
      req0_valid = 0; req0_inst = 0; req0_tag = 0;
      req1_valid = 0; req1_inst = 0; req1_tag = 0;
      out_ready = 0; cnt_clear = 0;
      m_reset();
      repeat (2) @(negedge clk);
      chk_out();
      rst_n = 1;

      // ADDI x1,x0,-1 from requester 0
      cyc(1, 32'hFFF00093, 4'h3, 0, 32'h0, 4'h0, 1, 0);
      cyc(0, 32'h0, 4'h0, 0, 32'h0, 4'h0, 1, 0);
      // Contention: LUI vs JAL, alternating grants
      for (int i = 0; i < 8; i++)
         cyc(1, 32'h123450B7, 4'h1, 1, 32'h0080006F, 4'h2, 1, 0);
      // Single requester 1: BEQ -4 then SW x1,12(x2)
      cyc(0, 32'h0, 4'h0, 1, 32'hFE000EE3, 4'h9, 1, 0);
      cyc(0, 32'h0, 4'h0, 1, 32'h00112623, 4'hA, 1, 0);
      // Stall: consumer not ready for 5 cycles with both valid
      for (int i = 0; i < 5; i++)
         cyc(1, 32'hFFF00093, 4'h4, 1, 32'h00112623, 4'h5, 0, 0);
      cyc(1, 32'hFFF00093, 4'h4, 1, 32'h00112623, 4'h5, 1, 0);
      cyc(0, 32'h0, 4'h0, 0, 32'h0, 4'h0, 1, 0);

      // Saturation of grant_cnt0, then clear colliding with a grant
      cyc(0, 32'h0, 4'h0, 0, 32'h0, 4'h0, 1, 1);
      for (int i = 0; i < CMAX + 1; i++)
         cyc(1, 32'h00500093, 4'h6, 0, 32'h0, 4'h0, 1, 0);
      @(negedge clk);
      chk("cnt0_saturated", grant_cnt0, CMAX);
      cyc(1, 32'h00500093, 4'h6, 0, 32'h0, 4'h0, 1, 1);
      cyc(0, 32'h0, 4'h0, 0, 32'h0, 4'h0, 1, 0);

      // Random traffic
      for (int i = 0; i < 400; i++)
         cyc($urandom_range(0, 3) != 0, rnd_inst(), 4'($urandom),
             $urandom_range(0, 3) != 0, rnd_inst(), 4'($urandom),
             $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);

      // Reset while a result is held stalled
      cyc(0, 32'h0, 4'h0, 1, 32'h00112623, 4'h7, 1, 0);
      cyc(0, 32'h0, 4'h0, 0, 32'h0, 4'h0, 0, 0);
      @(negedge clk);
      chk_out();
      chk("stalled_valid", out_valid, 1);
      rst_n = 0;
      #1;
      m_reset();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_cnt1", grant_cnt1, 0);
      @(negedge clk);
      rst_n = 1;
      cyc(1, 32'h123450B7, 4'h1, 1, 32'h0080006F, 4'h2, 1, 0);
      cyc(0, 32'h0, 4'h0, 0, 32'h0, 4'h0, 1, 0);
      @(negedge clk);
      chk_out();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/imm_gen_arbiter.md
Name: imm_gen_arbiter

Overview:
- Shares one combinational RISC-V immediate generator between two instruction requesters, e.g. the decode stage and the debug/monitor injector.
- Round-robin arbitration over two valid/ready request ports.
- The decoded immediate, instruction, source ID and tag go into a single registered output slot with valid/ready handshake.
- Sits between instruction sources and the execute-side operand mux.

Parameters:
- TAG_W, 4, width of the per-request tag carried through unchanged.
- CNT_W, 16, width of each saturating per-requester grant counter.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an instruction.
- req0_inst  in  32  requester 0 instruction word.
- req0_tag  in  TAG_W  requester 0 tag.
- req0_ready  out  1  requester 0 accepted this cycle.
- req1_valid  in  1  requester 1 has an instruction.
- req1_inst  in  32  requester 1 instruction word.
- req1_tag  in  TAG_W  requester 1 tag.
- req1_ready  out  1  requester 1 accepted this cycle.
- out_valid  out  1  output slot holds a result.
- out_ready  in  1  consumer takes the result this cycle.
- out_imm  out  32  generated immediate.
- out_inst  out  32  instruction that produced out_imm.
- out_src  out  1  granted requester (0/1).
- out_tag  out  TAG_W  tag of granted request.
- cnt_clear  in  1  synchronous clear of both grant counters.
- grant_cnt0  out  CNT_W  saturating count of requester-0 grants.
- grant_cnt1  out  CNT_W  saturating count of requester-1 grants.

Behaviour:
- Reset: out_valid=0; out_imm, out_inst, out_tag, out_src = 0; grant counters=0; last_grant=1, so requester 0 wins first.
- slot_free = !out_valid | out_ready. Arbitration happens only when slot_free.
- Grant rule when slot_free:
  - Only one valid requester: it is granted.
  - Both valid: grant !last_grant.
  - Neither valid: no grant.
- reqN_ready = slot_free & grant to N. Combinational; depends on valid, never the reverse.
- On a grant, at the next edge:
  - out_valid=1; out_* loaded from the granted requester plus the immediate decoded from its inst.
  - last_grant updated to the winner.
  - Winner's counter increments.
- On no grant: if out_ready & out_valid, out_valid becomes 0. Data registers hold their values.
- Latency: 1 cycle, accept to out_valid. Back-to-back throughput of 1 per cycle when out_ready is held high.
- Output stability: while out_valid & !out_ready, all out_* hold, no grant occurs, and both ready outputs are 0.
- Immediate decode, key = {inst[6:5], inst[3:2]}:
  - 0000 I: sext(inst[31:20]).
  - 1101 JALR: sext({inst[31:21], 0}).
  - 0100 S: sext({inst[31:25], inst[11:7]}).
  - 0101 and 0001 U: {inst[31:12], 12'b0}.
  - 1111 J: sext({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
  - 1100 B: sext({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
  - Any other key: I-type rule.
- Counters:
  - Saturate at 2^CNT_W-1.
  - cnt_clear has priority over increment in the same cycle; result is 0.
  - cnt_clear does not affect the datapath.
- Reset asserted mid-transfer: all state returns to reset values immediately. The in-flight result is discarded with no handshake completion.

Test Plan:
- Reset release, requester 0 sends 0xFFF00093 (ADDI x1,x0,-1), out_ready=1 -> req0_ready=1 same cycle. Next cycle out_valid=1, out_imm=0xFFFFFFFF, out_src=0, grant_cnt0=1.
- Both valid every cycle, out_ready=1; req0 sends 0x123450B7 (LUI), req1 sends 0x0080006F (JAL) -> grants alternate 0,1,0,1. out_imm alternates 0x12345000 and 0x00000008. Counters equal after an even number of cycles.
- Single requester 1 sends 0xFE000EE3 (BEQ, offset -4) -> out_imm=0xFFFFFFFC. Then 0x00112623 (SW x1,12(x2)) -> out_imm=0x0000000C. out_tag matches req1_tag each time.
- out_ready=0 for 5 cycles with both requesters valid -> out_* unchanged and both ready outputs 0 throughout. On out_ready=1, one grant follows the round-robin order.
- Preload grant_cnt0 to saturation with CNT_W=4 (15 grants), then one more grant -> stays 15. Assert cnt_clear together with a grant -> counter reads 0.
- Assert rst_n=0 while out_valid=1 and out_ready=0 -> out_valid=0 immediately. After release, requester 0 wins the first contention.
